// File: rtl/aes_core_ctrl_pkg.sv
// rtl/aes_core_ctrl_pkg.sv - shared encodings for the AES core sequencer
// State encoding, command opcodes and key-length codes used by the controller.
package aes_core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_KEY_START = 3'd1,
    ST_KEY_WAIT  = 3'd2,
    ST_BLK_START = 3'd3,
    ST_BLK_WAIT  = 3'd4,
    ST_RESP      = 3'd5
  } state_t;

  localparam logic CMD_OP_KEY      = 1'b0;
  localparam logic CMD_OP_BLK      = 1'b1;
  localparam logic AES_128_BIT_KEY = 1'b0;
  localparam logic AES_256_BIT_KEY = 1'b1;

  // The cipher datapath owns the S-box only while a block is being started or run.
  function automatic logic is_blk_state(input state_t s);
    return (s == ST_BLK_START) || (s == ST_BLK_WAIT);
  endfunction

endpackage

// File: rtl/aes_core_ctrl_if.sv
// rtl/aes_core_ctrl_if.sv - command and response handshake bundle
// Master is the command issuer; slave is the sequencer.
interface aes_core_ctrl_if;

  logic cmd_valid;
  logic cmd_ready;
  logic cmd_op;
  logic cmd_keylen;
  logic done_valid;
  logic done_err;
  logic done_ready;

  modport master (
    output cmd_valid, cmd_op, cmd_keylen, done_ready,
    input  cmd_ready, done_valid, done_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_keylen, done_ready,
    output cmd_ready, done_valid, done_err
  );

endinterface

// File: rtl/aes_core_ctrl_engine_wait.sv
// rtl/aes_core_ctrl_engine_wait.sv - busy-engine completion and timeout tracker
// Shared by the key and block paths; the caller selects which ready it watches.
module aes_core_ctrl_engine_wait #(
  parameter int TIMEOUT_CYCLES = 32,
  parameter int TMR_W          = 6
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_start,
  input  logic i_active,
  input  logic i_engine_ready,
  output logic o_complete,
  output logic o_timeout
);

  localparam logic [TMR_W-1:0] LP_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] r_timer;
  logic             r_seen_lo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer   <= '0;
      r_seen_lo <= 1'b0;
    end else if (i_start) begin
      r_timer   <= '0;
      r_seen_lo <= 1'b0;
    end else if (i_active) begin
      r_timer <= r_timer + TMR_W'(1);
      if (!i_engine_ready) begin
        r_seen_lo <= 1'b1;
      end
    end
  end

  // A ready that never dropped is the engine's idle level, not a finish.
  assign o_complete = i_active & r_seen_lo & i_engine_ready;
  assign o_timeout  = i_active & (r_timer == LP_LAST);

endmodule

// File: rtl/aes_core_ctrl.sv
// rtl/aes_core_ctrl.sv - AES core top-level command sequencer
// Runs key loads and block commands against the key memory and cipher datapath.
module aes_core_ctrl
  import aes_core_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32,
  parameter int TMR_W          = 6
) (
  input  logic           clk,
  input  logic           reset_n,
  aes_core_ctrl_if.slave bus,
  input  logic           i_key_ready,
  input  logic           i_enc_ready,
  output logic           o_keylen,
  output logic           o_key_init,
  output logic           o_enc_next,
  output logic           o_sbox_sel,
  output logic           o_key_valid,
  output logic           o_busy
);

  state_t r_state;
  logic   r_keylen;
  logic   r_key_valid;
  logic   r_done_err;

  logic w_start;
  logic w_active;
  logic w_engine_ready;
  logic w_complete;
  logic w_timeout;

  assign w_start        = (r_state == ST_KEY_START) || (r_state == ST_BLK_START);
  assign w_active       = (r_state == ST_KEY_WAIT)  || (r_state == ST_BLK_WAIT);
  assign w_engine_ready = (r_state == ST_BLK_WAIT) ? i_enc_ready : i_key_ready;

  aes_core_ctrl_engine_wait #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) u_engine_wait (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_start        (w_start),
    .i_active       (w_active),
    .i_engine_ready (w_engine_ready),
    .o_complete     (w_complete),
    .o_timeout      (w_timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_keylen    <= AES_128_BIT_KEY;
      r_key_valid <= 1'b0;
      r_done_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_op == CMD_OP_KEY) begin
              r_keylen    <= bus.cmd_keylen;
              r_key_valid <= 1'b0;
              r_state     <= ST_KEY_START;
            end else if (r_key_valid) begin
              r_state <= ST_BLK_START;
            end else begin
              r_done_err <= 1'b1;
              r_state    <= ST_RESP;
            end
          end
        end
        ST_KEY_START: r_state <= ST_KEY_WAIT;
        ST_KEY_WAIT: begin
          // Completion is checked first so it wins a same-cycle timeout.
          if (w_complete) begin
            r_key_valid <= 1'b1;
            r_done_err  <= 1'b0;
            r_state     <= ST_RESP;
          end else if (w_timeout) begin
            r_done_err <= 1'b1;
            r_state    <= ST_RESP;
          end
        end
        ST_BLK_START: r_state <= ST_BLK_WAIT;
        ST_BLK_WAIT: begin
          if (w_complete) begin
            r_done_err <= 1'b0;
            r_state    <= ST_RESP;
          end else if (w_timeout) begin
            r_done_err <= 1'b1;
            r_state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.done_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake and strobe outputs depend on the state register alone.
  assign bus.cmd_ready  = (r_state == ST_IDLE);
  assign bus.done_valid = (r_state == ST_RESP);
  assign bus.done_err   = r_done_err;
  assign o_key_init     = (r_state == ST_KEY_START);
  assign o_enc_next     = (r_state == ST_BLK_START);
  assign o_sbox_sel     = is_blk_state(r_state);
  assign o_busy         = (r_state != ST_IDLE);
  assign o_keylen       = r_keylen;
  assign o_key_valid    = r_key_valid;

endmodule

// File: tb/tb_aes_core_ctrl.sv
// tb/tb_aes_core_ctrl.sv - self-checking bench for the AES core sequencer
// Engine stubs answer start pulses; expectations come from tables and a command-level model.
module tb_aes_core_ctrl;

  localparam int TIMEOUT = 32;
  localparam int MAX_CYC = 60;

  logic clk = 1'b0;
  logic reset_n;
  logic key_ready, enc_ready;
  logic o_keylen, o_key_init, o_enc_next, o_sbox_sel, o_key_valid, o_busy;

  aes_core_ctrl_if bus();

  aes_core_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .TMR_W(6)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .i_key_ready (key_ready),
    .i_enc_ready (enc_ready),
    .o_keylen    (o_keylen),
    .o_key_init  (o_key_init),
    .o_enc_next  (o_enc_next),
    .o_sbox_sel  (o_sbox_sel),
    .o_key_valid (o_key_valid),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  // Command-level reference: what the response looks like, not how the FSM gets there.
  bit m_key_valid = 1'b0;
  bit m_keylen    = 1'b0;

  task automatic model(input bit op, input bit kl, input int lat,
                       output int e_lat, output bit e_err, output bit e_pulse);
    bit finishes;
    finishes = (lat >= 1) && (lat <= TIMEOUT - 1);
    if (op == 1'b1 && !m_key_valid) begin
      e_lat = 1; e_err = 1'b1; e_pulse = 1'b0;
    end else begin
      e_pulse = 1'b1;
      e_lat   = finishes ? lat + 3 : TIMEOUT + 2;
      e_err   = !finishes;
      if (op == 1'b0) begin
        m_keylen    = kl;
        m_key_valid = finishes;
      end
    end
  endtask

  // Drives one command from a falling edge with the DUT idle; stub keeps ready low for lat cycles.
  task automatic run_cmd(input bit op, input bit kl, input int lat, input int hold, input int idx,
                         input int e_lat, input bit e_err, input bit e_pulse,
                         input bit e_kv, input bit e_kl);
    int cyc, pulse_at, n_init, n_next, sbox_bad, busy_bad, hold_bad;
    bit got, rdy;
    cyc = 1; pulse_at = -1; n_init = 0; n_next = 0;
    sbox_bad = 0; busy_bad = 0; hold_bad = 0; got = 1'b0;
    chk("cmd_ready_idle", idx, bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_keylen = kl;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.cmd_op = 1'($urandom); bus.cmd_keylen = 1'($urandom);
    while (cyc <= MAX_CYC) begin
      if (o_key_init) n_init++;
      if (o_enc_next) n_next++;
      if (pulse_at < 0 && ((op == 1'b0 && o_key_init) || (op == 1'b1 && o_enc_next))) pulse_at = cyc;
      if (o_sbox_sel !== (op && e_pulse && cyc < e_lat)) sbox_bad++;
      if (o_busy !== 1'b1) busy_bad++;
      rdy = !(pulse_at >= 0 && cyc > pulse_at && cyc <= pulse_at + lat);
      if (op == 1'b0) begin key_ready = rdy; enc_ready = 1'($urandom); end
      else begin enc_ready = rdy; key_ready = 1'($urandom); end
      if (bus.done_valid === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
      cyc++;
    end
    chk("resp_latency", idx, got ? cyc : -1, e_lat);
    chk("done_err", idx, bus.done_err, e_err);
    chk("key_init_pulses", idx, n_init, (op == 1'b0) ? 1 : 0);
    chk("enc_next_pulses", idx, n_next, (op == 1'b1 && e_pulse) ? 1 : 0);
    chk("sbox_sel_cycles_bad", idx, sbox_bad, 0);
    chk("busy_cycles_bad", idx, busy_bad, 0);
    for (int h = 0; h < hold; h++) begin
      bus.done_ready = 1'b0;
      key_ready = 1'($urandom); enc_ready = 1'($urandom);
      @(negedge clk);
      if (!(bus.done_valid === 1'b1 && bus.done_err === e_err && bus.cmd_ready === 1'b0)) hold_bad++;
    end
    if (hold > 0) chk("resp_hold_unstable", idx, hold_bad, 0);
    bus.done_ready = 1'b1;
    @(negedge clk);
    bus.done_ready = 1'b0;
    key_ready = 1'b1; enc_ready = 1'b1;
    chk("done_valid_drop", idx, bus.done_valid, 0);
    chk("cmd_ready_back", idx, bus.cmd_ready, 1);
    chk("key_valid", idx, o_key_valid, e_kv);
    chk("keylen", idx, o_keylen, e_kl);
  endtask

  typedef struct {
    bit op; bit kl; int lat; int hold;
    int e_lat; bit e_err; bit e_pulse; bit e_kv; bit e_kl;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int e_lat;
    bit e_err, e_pulse, op, kl;
    int lat, r;

    //          op  kl  lat hold  lat err pulse kv kl
    tbl[0] = '{1'b1, 1'b0,  5, 0,   1, 1'b1, 1'b0, 1'b0, 1'b0};  // block without key
    tbl[1] = '{1'b0, 1'b0, 13, 0,  16, 1'b0, 1'b1, 1'b1, 1'b0};  // 128-bit key load
    tbl[2] = '{1'b1, 1'b0, 12, 0,  15, 1'b0, 1'b1, 1'b1, 1'b0};  // block with key
    tbl[3] = '{1'b0, 1'b1,  0, 5,  34, 1'b1, 1'b1, 1'b0, 1'b1};  // key ready stuck high
    tbl[4] = '{1'b1, 1'b0,  3, 0,   1, 1'b1, 1'b0, 1'b0, 1'b1};  // key lost after timeout
    tbl[5] = '{1'b0, 1'b1, 31, 1,  34, 1'b0, 1'b1, 1'b1, 1'b1};  // completion ties timeout
    tbl[6] = '{1'b1, 1'b0, 32, 0,  34, 1'b1, 1'b1, 1'b1, 1'b1};  // block timeout keeps key
    tbl[7] = '{1'b1, 1'b0,  1, 0,   4, 1'b0, 1'b1, 1'b1, 1'b1};  // shortest engine
    tbl[8] = '{1'b0, 1'b0,  1, 2,   4, 1'b0, 1'b1, 1'b1, 1'b0};  // reload to 128-bit

    reset_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_keylen = 1'b0; bus.done_ready = 1'b0;
    key_ready = 1'b0; enc_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", 0, bus.cmd_ready, 1);
    chk("reset_key_valid", 0, o_key_valid, 0);
    chk("reset_done_valid", 0, bus.done_valid, 0);
    chk("reset_sbox_sel", 0, o_sbox_sel, 0);
    chk("reset_busy", 0, o_busy, 0);
    chk("reset_keylen", 0, o_keylen, 0);
    key_ready = 1'b1; enc_ready = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_cmd(tbl[i].op, tbl[i].kl, tbl[i].lat, tbl[i].hold, i,
              tbl[i].e_lat, tbl[i].e_err, tbl[i].e_pulse, tbl[i].e_kv, tbl[i].e_kl);
      m_key_valid = tbl[i].e_kv;
      m_keylen    = tbl[i].e_kl;
    end

    // Reset while the cipher datapath is busy.
    bus.cmd_valid = 1'b1; bus.cmd_op = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    enc_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("blk_wait_sbox_sel", 100, o_sbox_sel, 1);
    chk("blk_wait_busy", 100, o_busy, 1);
    reset_n = 1'b0;
    #1;
    chk("midop_reset_key_valid", 100, o_key_valid, 0);
    chk("midop_reset_busy", 100, o_busy, 0);
    chk("midop_reset_cmd_ready", 100, bus.cmd_ready, 1);
    chk("midop_reset_sbox_sel", 100, o_sbox_sel, 0);
    chk("midop_reset_done_valid", 100, bus.done_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    enc_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_keylen", 100, o_keylen, 0);
    m_key_valid = 1'b0;
    m_keylen    = 1'b0;

    for (int i = 0; i < 30; i++) begin
      op = 1'($urandom);
      kl = 1'($urandom);
      r  = $urandom_range(0, 9);
      if (r == 0) lat = 0;
      else if (r == 1) lat = $urandom_range(30, 34);
      else lat = $urandom_range(1, 20);
      model(op, kl, lat, e_lat, e_err, e_pulse);
      run_cmd(op, kl, lat, $urandom_range(0, 3), 200 + i,
              e_lat, e_err, e_pulse, m_key_valid, m_keylen);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
